// File: rtl/wb_regfile.sv
// wb_regfile: EX/WB pipeline register, 32 x REG_WIDTH register file with
// three combinational operand read ports, a debug read port that looks only
// at the array, and a free-running commit counter.
// Optional feature macro: WB_BYPASS_EN. When it is defined, the read ports
// forward the pending WB value. When it is undefined, they read the array only.
module wb_regfile #(
    parameter int REG_WIDTH  = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] ex_dest,
    input  logic [REG_WIDTH-1:0]  ex_result,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rs3_addr,
    output logic [REG_WIDTH-1:0]  rs1_data,
    output logic [REG_WIDTH-1:0]  rs2_data,
    output logic [REG_WIDTH-1:0]  rs3_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [REG_WIDTH-1:0]  dbg_data,
    output logic                  wb_busy,
    output logic [CNT_WIDTH-1:0]  commit_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  wb_valid_reg;
    logic [ADDR_WIDTH-1:0] wb_dest_reg;
    logic [REG_WIDTH-1:0]  wb_result_reg;
    logic [CNT_WIDTH-1:0]  commit_cnt_reg;

    // The array is cleared asynchronously as a whole, so it is held in flops rather than block RAM.
    logic [REG_WIDTH-1:0]  regs_reg [DEPTH];

    // The read ports are gathered into arrays so that one generate loop can build all three.
    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [REG_WIDTH-1:0]  rd_data [3];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rd_addr[2] = rs3_addr;
    assign rs1_data   = rd_data[0];
    assign rs2_data   = rd_data[1];
    assign rs3_data   = rd_data[2];

    // Stage 1: capture the ALU result every cycle. There is no stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_reg  <= 1'b0;
            wb_dest_reg   <= '0;
            wb_result_reg <= '0;
        end else begin
            wb_valid_reg  <= ex_valid;
            wb_dest_reg   <= ex_dest;
            wb_result_reg <= ex_result;
        end
    end

    // Stage 2: commit the pending WB entry. A reset discards it without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_valid_reg) begin
            regs_reg[wb_dest_reg] <= wb_result_reg;
        end
    end

    // Count committed writes. The counter wraps around instead of saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt_reg <= '0;
        end else if (wb_valid_reg) begin
            commit_cnt_reg <= commit_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd
            // Operand read: the pending WB value overrides the array when forwarding is built in.
            always_comb begin
                rd_data[gi] = regs_reg[rd_addr[gi]];
`ifdef WB_BYPASS_EN
                if (wb_valid_reg && (rd_addr[gi] == wb_dest_reg)) begin
                    rd_data[gi] = wb_result_reg;
                end
`endif
            end
        end
    endgenerate

    assign dbg_data   = regs_reg[dbg_addr];
    assign wb_busy    = wb_valid_reg;
    assign commit_cnt = commit_cnt_reg;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and register file of the multimedia engine.
- Sits at the consumer end of the ALU interface: captures the 128-bit ALU result and its destination index into an EX/WB pipeline register, commits it to a 32 x 128-bit register file one cycle later, and serves the three operand reads (rs1/rs2/rs3) that feed the ALU.
- Includes WB-to-read bypass, a debug read port for benches, and a commit counter.

Parameters:
- REG_WIDTH, 128, register/operand width in bits
- ADDR_WIDTH, 5, register index width (32 registers)
- CNT_WIDTH, 32, commit counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ex_valid  input  1  ALU result this cycle is to be written back
- ex_dest  input  ADDR_WIDTH  destination register index
- ex_result  input  REG_WIDTH  ALU reg_rd output
- rs1_addr  input  ADDR_WIDTH  read port 1 index
- rs2_addr  input  ADDR_WIDTH  read port 2 index
- rs3_addr  input  ADDR_WIDTH  read port 3 index
- rs1_data  output  REG_WIDTH  read port 1 data (combinational)
- rs2_data  output  REG_WIDTH  read port 2 data (combinational)
- rs3_data  output  REG_WIDTH  read port 3 data (combinational)
- dbg_addr  input  ADDR_WIDTH  debug read index
- dbg_data  output  REG_WIDTH  debug read data, array only, never bypassed
- wb_busy  output  1  registered; high while a write sits in the WB register (equals wb_valid)
- commit_cnt  output  CNT_WIDTH  registered; number of committed writes

Behaviour:
- Reset (async, rst high), applied immediately, no clock needed:
  - wb_valid=0, wb_dest=0, wb_result=0, all 32 array entries=0, commit_cnt=0.
  - rs*/dbg_data therefore read 0; wb_busy=0.
- Stage 1, each rising edge: wb_valid<=ex_valid; wb_dest<=ex_dest; wb_result<=ex_result. Unconditional; no stall input.
- Stage 2, same edge: if wb_valid (old value), array[wb_dest]<=wb_result and commit_cnt<=commit_cnt+1.
- Latency: ex_result presented at edge N is in the array after edge N+1. With bypass it is readable on rs ports from N+1; on dbg_data from N+1 post-edge.
- Register 0 is an ordinary writable register; no hardwired zero.
- Read ports, combinational, per port independently: if bypass enabled and wb_valid and rsX_addr==wb_dest, rsX_data=wb_result; else rsX_data=array[rsX_addr].
- Back-to-back writes to the same dest: the older value commits at N+1 and the newer at N+2. Reads between edges return the newest WB value via bypass; no write is ever dropped.
- ex_valid=0 cycles create bubbles: wb_valid=0 and no commit.
- commit_cnt wraps modulo 2^CNT_WIDTH, no saturation.
- Reset asserted mid-operation discards any pending WB write; nothing is committed on the reset edge.
- Full-width writes only. Partial-field ops (e.g. LI) are merged by the ALU, which reads the old rd through rs1.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: read ports apply the WB bypass above.
- Undefined: read ports return array contents only. A read of wb_dest during the pending cycle returns the stale value, and the hazard becomes the issue logic's responsibility (one-cycle gap required). dbg_data is unaffected either way.

Test Plan:
- Reset: write 128'h1 to r3, pulse rst mid-cycle with no clock edge -> rs1_data (addr 3)=0, dbg_data=0, commit_cnt=0, wb_busy=0 immediately.
- Single write: ex_valid=1, ex_dest=5, ex_result=128'hDEAD_BEEF at edge 1, then ex_valid=0 -> wb_busy=1 after edge 1, dbg_data(5)=0 until edge 2 then DEAD_BEEF, commit_cnt=1.
- Bypass (WB_BYPASS_EN): after edge 1 above, rs2_addr=5 -> DEAD_BEEF before edge 2. Without macro -> 0 until edge 2.
- Back-to-back same dest: r7<=128'hAAAA at edge 1, r7<=128'hBBBB at edge 2 -> rs3 (addr 7) reads BBBB after edge 2 with bypass, array r7=BBBB after edge 3, commit_cnt=2.
- Three ports and bubble: preload r1=1, r2=2, r3=3; rs1/rs2/rs3=1/2/3 simultaneously -> 1/2/3. ex_valid=0 with ex_dest=1, ex_result=9 -> r1 stays 1, commit_cnt unchanged.
- Counter wrap: CNT_WIDTH=4, 17 valid writes -> commit_cnt=1.
